// File: rtl/cnu_pkg.sv
// rtl/cnu_pkg.sv - shared types, constants and helpers for the serial check node unit
//
// Purpose : default message width, saturating magnitude, correction mode
//           encodings, FSM state type and the x0.75 normalization helper.
// Ports   : none (package).
package cnu_pkg;

    localparam int CNU_DATA_W = 8;

    // Largest representable magnitude; -2^(W-1) saturates to this value.
    localparam logic [CNU_DATA_W-2:0] CNU_MAG_MAX = '1;

    localparam logic MODE_NORM = 1'b0;
    localparam logic MODE_OFFS = 1'b1;

    // Working width of the normalization helper; callers zero-extend into it.
    localparam int CNU_NORM_W = 16;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } cnu_state_e;

    // (3*m)>>2 with two guard bits so 3*m never wraps.
    function automatic logic [CNU_NORM_W-1:0] cnu_norm_3q4(input logic [CNU_NORM_W-1:0] m);
        logic [CNU_NORM_W+1:0] p;
        p = {2'b00, m} + {1'b0, m, 1'b0};
        return CNU_NORM_W'(p >> 2);
    endfunction

endpackage

// File: rtl/cnu_minfind.sv
// rtl/cnu_minfind.sv - sequential min/min2/min_idx/parity tracker
//
// Purpose : folds one (magnitude, sign, index) sample per valid cycle into the
//           two smallest magnitudes, the index of the smallest and the XOR of
//           all signs.
// Ports   : clk_i, rst_i (sync, active-high)
//           clear_i  - return to the empty state (row finished)
//           valid_i  - sample present this cycle
//           start_i  - sample is the first of a row; fold against empty state
//           mag_i, sign_i, idx_i - the sample
//           min_o, min2_o, min_idx_o, parity_o - running summary
module cnu_minfind #(
    parameter int MAG_W = 7,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             start_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic             sign_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [MAG_W-1:0] min_o,
    output logic [MAG_W-1:0] min2_o,
    output logic [IDX_W-1:0] min_idx_o,
    output logic             parity_o
);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    logic [MAG_W-1:0] min_q, min_d, min2_q, min2_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic             parity_q, parity_d;

    logic [MAG_W-1:0] base_min, base_min2;
    logic [IDX_W-1:0] base_idx;
    logic             base_par;

    always_comb begin
        base_min  = start_i ? MAG_MAX : min_q;
        base_min2 = start_i ? MAG_MAX : min2_q;
        base_idx  = start_i ? '0 : min_idx_q;
        base_par  = start_i ? 1'b0 : parity_q;

        min_d     = base_min;
        min2_d    = base_min2;
        min_idx_d = base_idx;
        parity_d  = base_par ^ sign_i;

        // Strict less-than: a tie keeps the earlier index and lands in min2.
        if (mag_i < base_min) begin
            min2_d    = base_min;
            min_d     = mag_i;
            min_idx_d = idx_i;
        end else if (mag_i < base_min2) begin
            min2_d = mag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            min_q     <= MAG_MAX;
            min2_q    <= MAG_MAX;
            min_idx_q <= '0;
            parity_q  <= 1'b0;
        end else if (valid_i) begin
            min_q     <= min_d;
            min2_q    <= min2_d;
            min_idx_q <= min_idx_d;
            parity_q  <= parity_d;
        end
    end

    assign min_o     = min_q;
    assign min2_o    = min2_q;
    assign min_idx_o = min_idx_q;
    assign parity_o  = parity_q;

endmodule

// File: rtl/cnu_serial.sv
// rtl/cnu_serial.sv - serial min-sum check node unit
//
// Purpose : accepts deg q messages (one per beat), then emits deg r messages
//           using min/min2 with normalized (x0.75) or offset correction.
// Config  : CNU_OFFSET_EN enables offset mode; without it mode/offset are
//           ignored and only the normalized path exists.
// Ports   : clk, rst (sync, active-high)
//           deg, mode, offset - row configuration, sampled on the first beat
//           in_valid/in_ready/in_q - q input stream
//           out_valid/out_ready/out_r/out_idx/out_last - r output stream
module cnu_serial
    import cnu_pkg::*;
#(
    parameter int D_MAX  = 16,
    parameter int DATA_W = CNU_DATA_W,
    parameter int IDX_W  = $clog2(D_MAX) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  deg,
    input  logic              mode,
    input  logic [DATA_W-2:0] offset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);
    localparam int MAG_W  = DATA_W - 1;
    localparam int SIDX_W = $clog2(D_MAX);
    localparam logic [IDX_W-1:0] DEG_LO  = IDX_W'(2);
    localparam logic [IDX_W-1:0] DEG_HI  = IDX_W'(D_MAX);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    cnu_state_e       state_q;
    logic             in_ready_q, out_valid_q, out_last_q;
    logic [IDX_W-1:0] count_q, deg_q, out_idx_q;
    logic [D_MAX-1:0] signs_q;

    logic             beat, out_fire, first_beat, row_done, q_sign;
    logic [IDX_W-1:0] deg_clamped, deg_d;
    logic [MAG_W-1:0] q_mag;

    logic [MAG_W-1:0] min_w, min2_w;
    logic [IDX_W-1:0] min_idx_w;
    logic             parity_w;

    logic [MAG_W-1:0]  m_sel, c_mag;
    logic [DATA_W-1:0] r_val;
    logic              r_neg;

    assign beat       = in_valid & in_ready_q;
    assign out_fire   = out_valid_q & out_ready;
    assign first_beat = (count_q == '0);
    assign q_sign     = in_q[DATA_W-1];

    // On the first beat the live deg port is used, later beats use the latch.
    always_comb begin
        if (deg < DEG_LO)      deg_clamped = DEG_LO;
        else if (deg > DEG_HI) deg_clamped = DEG_HI;
        else                   deg_clamped = deg;
        deg_d    = first_beat ? deg_clamped : deg_q;
        row_done = beat && (count_q == deg_d - IDX_W'(1));
    end

    // Saturating |q|: the most negative code has no positive twin.
    always_comb begin
        q_mag = in_q[MAG_W-1:0];
        if (q_sign) begin
            q_mag = (in_q[MAG_W-1:0] == '0) ? MAG_MAX : (~in_q[MAG_W-1:0] + MAG_W'(1));
        end
    end

    cnu_minfind #(
        .MAG_W (MAG_W),
        .IDX_W (IDX_W)
    ) u_minfind (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (out_fire & out_last_q),
        .valid_i   (beat),
        .start_i   (first_beat),
        .mag_i     (q_mag),
        .sign_i    (q_sign),
        .idx_i     (count_q),
        .min_o     (min_w),
        .min2_o    (min2_w),
        .min_idx_o (min_idx_w),
        .parity_o  (parity_w)
    );

`ifdef CNU_OFFSET_EN
    logic             mode_q;
    logic [MAG_W-1:0] offset_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_NORM;
            offset_q <= '0;
        end else if (beat && first_beat) begin
            mode_q   <= mode;
            offset_q <= offset;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, offset};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            count_q     <= '0;
            deg_q       <= DEG_LO;
            signs_q     <= '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (beat) begin
                        signs_q[count_q[SIDX_W-1:0]] <= q_sign;
                        if (first_beat) deg_q <= deg_clamped;
                        count_q <= count_q + IDX_W'(1);
                        if (row_done) begin
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            state_q     <= ST_COLLECT;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b0;
                            count_q     <= '0;
                            signs_q     <= '0;
                        end else begin
                            out_idx_q  <= out_idx_q + IDX_W'(1);
                            out_last_q <= (out_idx_q + IDX_W'(1)) == (deg_q - IDX_W'(1));
                        end
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    // r is a pure function of registered state, so it holds while stalled.
    always_comb begin
        m_sel = (out_idx_q == min_idx_w) ? min2_w : min_w;
        c_mag = MAG_W'(cnu_norm_3q4(CNU_NORM_W'(m_sel)));
`ifdef CNU_OFFSET_EN
        if (mode_q == MODE_OFFS) begin
            c_mag = (m_sel > offset_q) ? (m_sel - offset_q) : '0;
        end
`endif
        r_neg = parity_w ^ signs_q[out_idx_q[SIDX_W-1:0]];
        r_val = {1'b0, c_mag};
        if (r_neg) r_val = ~r_val + DATA_W'(1);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_valid_q ? r_val : '0;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_cnu_serial.sv
// tb/tb_cnu_serial.sv - directed self-checking bench for cnu_serial
module tb_cnu_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] deg;
    logic       mode;
    logic [6:0] offset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_q;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r;
    logic [4:0] out_idx;
    logic       out_last;

    int errors = 0;
    int checks = 0;
    int qv [16];
    int rv [16];

    cnu_serial dut (
        .clk       (clk),
        .rst       (rst),
        .deg       (deg),
        .mode      (mode),
        .offset    (offset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input int q, input int r);
        qv[i] = q;
        rv[i] = r;
    endtask

    task automatic push(input int v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_q = 8'(v);
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic pull(input int n, input int stall_at, input int hold_n);
        for (int k = 0; k < n; k++) begin
            int t;
            out_ready = 1'b1;
            in_valid = (k < hold_n);
            in_q = 8'd77;
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("out_valid[%0d]", k), out_valid, 1);
            if (k == stall_at) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_r", int'($signed(out_r)), rv[k]);
                    check("stall_idx", out_idx, k);
                    check("stall_last", out_last, (k == n - 1) ? 1 : 0);
                    check("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            check($sformatf("r[%0d]", k), int'($signed(out_r)), rv[k]);
            check($sformatf("idx[%0d]", k), out_idx, k);
            check($sformatf("last[%0d]", k), out_last, (k == n - 1) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
    endtask

    task automatic run_row(input int d, input int md, input int off, input int n,
                           input int stall_at, input int hold_n);
        deg = 5'(d);
        mode = 1'(md);
        offset = 7'(off);
        for (int i = 0; i < n; i++) begin
            push(qv[i]);
            deg = 5'd3;
            if (i == n - 2) check("pre_last_valid", out_valid, 0);
        end
        check("latency_valid", out_valid, 1);
        check("emit_in_ready", in_ready, 0);
        pull(n, stall_at, hold_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        deg = '0;
        mode = 1'b0;
        offset = '0;
        in_valid = 1'b0;
        in_q = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);

        // Normalized, with 3-cycle stall at idx 1.
        set_vec(0, 10, 2); set_vec(1, -3, -5); set_vec(2, 7, 2); set_vec(3, -20, -2);
        run_row(4, 0, 0, 4, 1, 0);

        // Offset mode (or ignored mode when the feature is absent).
`ifdef CNU_OFFSET_EN
        set_vec(0, 10, 2); set_vec(1, -3, -6); set_vec(2, 7, 2); set_vec(3, -20, -2);
`else
        set_vec(0, 10, 2); set_vec(1, -3, -5); set_vec(2, 7, 2); set_vec(3, -20, -2);
`endif
        run_row(4, 1, 1, 4, -1, 0);

        // Tie and saturation.
        set_vec(0, 5, -3); set_vec(1, 5, -3); set_vec(2, -128, 3);
        run_row(3, 0, 0, 3, -1, 0);

        // Reset in the middle of collecting a row.
        deg = 5'd4;
        mode = 1'b0;
        push(10);
        deg = 5'd3;
        push(-3);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        set_vec(0, 4, -6); set_vec(1, -8, 3);
        run_row(2, 0, 0, 2, -1, 0);

        // deg=0 clamps to 2.
        set_vec(0, 4, -6); set_vec(1, -8, 3);
        run_row(0, 0, 0, 2, -1, 0);

        // deg above D_MAX clamps to 16; in_valid held during part of EMIT.
        for (int i = 0; i < 16; i++) begin
            if (i == 7) set_vec(i, -6, 11);
            else        set_vec(i, 30 - i, -4);
        end
        run_row(19, 0, 0, 16, 9, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
